// File: rtl/thermostat_pkg.sv
// rtl/thermostat_pkg.sv - shared state/mode codes and default thresholds for the multizone thermostat
package thermostat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAT = 2'd1,
    ST_COOL = 2'd2
  } zone_state_t;

  typedef enum logic [1:0] {
    MODE_OFF       = 2'd0,
    MODE_HEAT_ONLY = 2'd1,
    MODE_COOL_ONLY = 2'd2,
    MODE_AUTO      = 2'd3
  } mode_t;

  localparam int DEF_HEAT_ON_TH  = 18;
  localparam int DEF_HEAT_OFF_TH = 20;
  localparam int DEF_COOL_ON_TH  = 22;
  localparam int DEF_COOL_OFF_TH = 20;

endpackage

// File: rtl/thermostat_zone.sv
// rtl/thermostat_zone.sv - one zone: IDLE/HEAT/COOL hysteresis FSM with minimum-dwell counter
module thermostat_zone
  import thermostat_pkg::*;
#(
  parameter int TEMP_W    = 5,
  parameter int DWELL_W   = 8,
  parameter int MIN_DWELL = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [TEMP_W-1:0] temp,
  input  logic [TEMP_W-1:0] heat_on_th,
  input  logic [TEMP_W-1:0] heat_off_th,
  input  logic [TEMP_W-1:0] cool_on_th,
  input  logic [TEMP_W-1:0] cool_off_th,
  input  logic              cfg_bad,
  output logic [1:0]        state_code,
  output logic              next_active,
  output logic              heating,
  output logic              cooling
);

  localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(MIN_DWELL);

  zone_state_t        state;
  zone_state_t        state_next;
  logic [DWELL_W-1:0] dwell;
  logic               dwell_ok;
  logic               heat_en;
  logic               cool_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      dwell <= DWELL_MAX;
    end else if (cfg_bad) begin
      state <= ST_IDLE;
      dwell <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        dwell <= '0;
      end else if (dwell < DWELL_MAX) begin
        dwell <= dwell + 1'b1;
      end
    end
  end

  // Forced exits (OFF, opposing single-direction mode, bad config) skip the dwell check.
  always_comb begin
    state_next = state;
    dwell_ok   = (dwell == DWELL_MAX);
    heat_en    = (mode == MODE_HEAT_ONLY) || (mode == MODE_AUTO);
    cool_en    = (mode == MODE_COOL_ONLY) || (mode == MODE_AUTO);
    case (state)
      ST_IDLE: begin
        if (dwell_ok && heat_en && (temp <= heat_on_th)) begin
          state_next = ST_HEAT;
        end else if (dwell_ok && cool_en && (temp >= cool_on_th)) begin
          state_next = ST_COOL;
        end
      end
      ST_HEAT: begin
        if (!heat_en) begin
          state_next = ST_IDLE;
        end else if (dwell_ok && (temp >= heat_off_th)) begin
          state_next = ST_IDLE;
        end
      end
      ST_COOL: begin
        if (!cool_en) begin
          state_next = ST_IDLE;
        end else if (dwell_ok && (temp <= cool_off_th)) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (cfg_bad) begin
      state_next = ST_IDLE;
    end
  end

  assign state_code  = state;
  assign next_active = (state_next != ST_IDLE);
  assign heating     = (state == ST_HEAT);
  assign cooling     = (state == ST_COOL);

endmodule

// File: rtl/thermostat_multizone.sv
// rtl/thermostat_multizone.sv - N-zone thermostat: threshold check, per-zone FSMs, aggregate activity flag
module thermostat_multizone
  import thermostat_pkg::*;
#(
  parameter int N_ZONES   = 4,
  parameter int TEMP_W    = 5,
  parameter int DWELL_W   = 8,
  parameter int MIN_DWELL = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                mode,
  input  logic [N_ZONES*TEMP_W-1:0] temperature,
  input  logic [TEMP_W-1:0]         heat_on_th,
  input  logic [TEMP_W-1:0]         heat_off_th,
  input  logic [TEMP_W-1:0]         cool_on_th,
  input  logic [TEMP_W-1:0]         cool_off_th,
  output logic [N_ZONES-1:0]        heating,
  output logic [N_ZONES-1:0]        cooling,
  output logic [2*N_ZONES-1:0]      zone_state,
  output logic                      config_err,
  output logic                      any_active
);

  logic               cfg_bad;
  logic [N_ZONES-1:0] next_active;

  // Thresholds must nest as heat_on < heat_off <= cool_off < cool_on.
  assign cfg_bad = !((heat_on_th < heat_off_th) &&
                     (heat_off_th <= cool_off_th) &&
                     (cool_off_th < cool_on_th));

  for (genvar i = 0; i < N_ZONES; i++) begin : g_zone
    thermostat_zone #(
      .TEMP_W    (TEMP_W),
      .DWELL_W   (DWELL_W),
      .MIN_DWELL (MIN_DWELL)
    ) u_zone (
      .clk         (clk),
      .rst         (rst),
      .mode        (mode),
      .temp        (temperature[i*TEMP_W +: TEMP_W]),
      .heat_on_th  (heat_on_th),
      .heat_off_th (heat_off_th),
      .cool_on_th  (cool_on_th),
      .cool_off_th (cool_off_th),
      .cfg_bad     (cfg_bad),
      .state_code  (zone_state[2*i +: 2]),
      .next_active (next_active[i]),
      .heating     (heating[i]),
      .cooling     (cooling[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      config_err <= 1'b0;
      any_active <= 1'b0;
    end else begin
      config_err <= cfg_bad;
      any_active <= |next_active;
    end
  end

endmodule

// File: doc/thermostat_multizone.md
Name: thermostat_multizone

Overview:
- N-zone successor to the single-zone heating/cooling controller. Each zone runs an independent hysteresis FSM (IDLE/HEAT/COOL) against shared, runtime-programmable thresholds.
- Adds a global operating mode, a minimum-dwell timer per zone (compressor/boiler protection) and threshold-consistency checking.
- Sits between the temperature-sensor front end and the per-zone actuator drivers.

Parameters:
N_ZONES, 4, number of independent zones (1..16)
TEMP_W, 5, temperature/threshold width, unsigned
DWELL_W, 8, width of the per-zone dwell counter
MIN_DWELL, 16, minimum cycles a zone stays in any state before a non-forced transition (1..2^DWELL_W-1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
mode  in  2  0=OFF, 1=HEAT_ONLY, 2=COOL_ONLY, 3=AUTO
temperature  in  N_ZONES*TEMP_W  zone i occupies bits [i*TEMP_W +: TEMP_W]
heat_on_th  in  TEMP_W  enter HEAT when temp <= this
heat_off_th  in  TEMP_W  leave HEAT when temp >= this
cool_on_th  in  TEMP_W  enter COOL when temp >= this
cool_off_th  in  TEMP_W  leave COOL when temp <= this
heating  out  N_ZONES  zone heater on
cooling  out  N_ZONES  zone cooler on
zone_state  out  2*N_ZONES  per-zone state code, 2 bits per zone
config_err  out  1  thresholds inconsistent; all zones forced IDLE
any_active  out  1  OR of all heating|cooling bits

Behaviour:
- Reset (rst=1 at a rising edge):
  - All zones go to IDLE. heating=0, cooling=0, zone_state=IDLE, config_err=0, any_active=0.
  - Dwell counters load to saturated (MIN_DWELL), so the first decision after reset is not delayed.
- State codes: IDLE=0, HEAT=1, COOL=2; 3 is unused and decodes to IDLE.
- Outputs are registered:
  - temperature/mode/thresholds sampled at edge k produce outputs valid after edge k+1 (one-cycle latency).
  - heating[i] = (state==HEAT); cooling[i] = (state==COOL). The two are never both 1.
- config_err:
  - Registered, one-cycle latency.
  - Set when the condition heat_on_th < heat_off_th <= cool_off_th < cool_on_th is false.
  - While set, all zones are forced to IDLE and dwell counters are cleared to 0.
- Dwell counter, per zone:
  - Resets to 0 on every state change.
  - Increments each cycle otherwise and saturates at MIN_DWELL.
  - A non-forced transition is allowed only when the counter == MIN_DWELL.
- Transitions, per zone (comparisons unsigned, full TEMP_W):
  - IDLE -> HEAT: temp <= heat_on_th, mode in {HEAT_ONLY, AUTO}, dwell satisfied.
  - IDLE -> COOL: temp >= cool_on_th, mode in {COOL_ONLY, AUTO}, dwell satisfied.
  - HEAT -> IDLE: temp >= heat_off_th and dwell satisfied.
  - COOL -> IDLE: temp <= cool_off_th and dwell satisfied.
  - HEAT <-> COOL directly: never allowed; a zone always passes through IDLE.
- Forced transitions ignore dwell:
  - mode=OFF, or config_err, sends every zone to IDLE on the next edge.
  - mode changed to COOL_ONLY while in HEAT: forced to IDLE. Symmetric for HEAT_ONLY while in COOL.
- Boundaries:
  - temp == 0 and temp == 2^TEMP_W-1 are valid inputs with no wrap.
  - A threshold change mid-operation takes effect on the next edge and respects dwell, unless it causes config_err.
- Zones are fully independent. Simultaneous transitions in several zones are legal.
- any_active is registered, derived from next-state values, so it stays aligned with heating/cooling.

Decomposition:
- Shared package/header `thermostat_pkg`:
  - State codes IDLE/HEAT/COOL.
  - Mode codes OFF/HEAT_ONLY/COOL_ONLY/AUTO.
  - Default thresholds 18/20/22/20.
- Sub-module `thermostat_zone`: one FSM plus dwell counter, instantiated N_ZONES times via generate.
- Top level holds the config check, the config_err register and any_active.

Test Plan:
- Reset, then mode=AUTO, thresholds 18/20/22/20, zone0 temp=17, MIN_DWELL=16 -> heating[0]=1 one cycle after rst deasserts.
- Zone0 in HEAT, temp raised to 20 at dwell=5 -> heating[0] stays 1 until dwell reaches 16, then 0 next cycle.
- Zone1 temp sweeps 0..31..0 in AUTO -> cooling[1] rises at 22 (after dwell) and falls at 20; heating[1] rises at 18 and falls at 20; heating and cooling are never both 1.
- mode switched to OFF while zones 0..3 are active -> all heating/cooling=0 on the next edge regardless of dwell; any_active=0.
- heat_off_th set to 23 (greater than cool_off_th=20) -> config_err=1 next cycle, all outputs 0; restore 20 -> config_err=0 and the dwell restart is honoured.
- rst asserted for 1 cycle mid-HEAT with temp=10 -> heating=0 on that edge; heating=1 again one cycle after release, with no dwell wait.
